// File: rtl/conv_window_feeder_pkg.sv
// Shared types and constants for the binary convolver operand path.
// No logic here: state encoding and operand word layout only.
package conv_pkg;

  localparam int CONV_WIDTH = 6;

  // Operand word layout: kernel in the upper half, window in the lower half.
  localparam int KERNEL_LSB = 6;
  localparam int WINDOW_LSB = 0;

  typedef enum logic [1:0] {
    NOKERNEL = 2'd0,
    COLLECT  = 2'd1,
    HOLD     = 2'd2
  } state_t;

endpackage

// File: rtl/conv_window_feeder_if.sv
// Kernel load, serial sample stream and operand handshake bundle.
// slave = the feeder; master = the side driving samples and consuming operands.
interface conv_window_feeder_if
  import conv_pkg::*;
#(
  parameter int WIDTH = CONV_WIDTH,
  parameter int IDX_W = 8
);

  logic [WIDTH-1:0]   kernel_in;
  logic               kernel_load;
  logic               sample_bit;
  logic               sample_valid;
  logic               sample_ready;
  logic               op_valid;
  logic               op_ready;
  logic [2*WIDTH-1:0] op_data;
  logic [IDX_W-1:0]   op_index;
  logic               kernel_valid;

  modport master (
    output kernel_in, kernel_load, sample_bit, sample_valid, op_ready,
    input  sample_ready, op_valid, op_data, op_index, kernel_valid
  );

  modport slave (
    input  kernel_in, kernel_load, sample_bit, sample_valid, op_ready,
    output sample_ready, op_valid, op_data, op_index, kernel_valid
  );

endinterface

// File: rtl/conv_window_feeder_window_shift_reg.sv
// WIDTH-bit register shifting new bits in at the MSB; oldest bit sits at bit 0.
// One-cycle update; clear has priority over shift.
module window_shift_reg #(
  parameter int WIDTH = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift,
  input  logic             bit_in,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      data <= '0;
    end else if (clear) begin
      data <= '0;
    end else if (shift) begin
      data <= {bit_in, data[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/conv_window_feeder.sv
// Builds {kernel, window} operand words from a serial bit stream with configurable stride.
// op_valid one cycle after the final sample; samples stall (sample_ready=0) while an operand waits.
module conv_window_feeder
  import conv_pkg::*;
#(
  parameter int WIDTH  = CONV_WIDTH,
  parameter int STRIDE = 1,
  parameter int IDX_W  = 8
) (
  input logic                 clock,
  input logic                 reset,
  conv_window_feeder_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  logic [CNT_W-1:0] need_cnt;
  logic [WIDTH-1:0] kernel;
  logic [WIDTH-1:0] window;
  logic             op_valid_q;
  logic [IDX_W-1:0] op_index_q;
  logic             kernel_valid_q;
  logic             accept;

  assign accept = bus.sample_valid && (state == COLLECT);

  // A kernel load flushes the window and discards any sample arriving with it.
  window_shift_reg #(
    .WIDTH (WIDTH)
  ) u_window (
    .clock  (clock),
    .reset  (reset),
    .clear  (bus.kernel_load),
    .shift  (accept && !bus.kernel_load),
    .bit_in (bus.sample_bit),
    .data   (window)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= NOKERNEL;
      kernel         <= '0;
      need_cnt       <= CNT_W'(WIDTH);
      op_valid_q     <= 1'b0;
      op_index_q     <= '0;
      kernel_valid_q <= 1'b0;
    end else if (bus.kernel_load) begin
      // Any pending operand is abandoned without counting a handshake.
      state          <= COLLECT;
      kernel         <= bus.kernel_in;
      need_cnt       <= CNT_W'(WIDTH);
      op_valid_q     <= 1'b0;
      kernel_valid_q <= 1'b1;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            need_cnt <= need_cnt - 1'b1;
            if (need_cnt == CNT_W'(1)) begin
              state      <= HOLD;
              op_valid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.op_ready) begin
            // Window is kept so the next operand overlaps by WIDTH-STRIDE bits.
            state      <= COLLECT;
            need_cnt   <= CNT_W'(STRIDE);
            op_valid_q <= 1'b0;
            op_index_q <= op_index_q + 1'b1;
          end
        end
        default: begin
          state <= NOKERNEL;
        end
      endcase
    end
  end

  assign bus.sample_ready = (state == COLLECT);
  assign bus.op_valid     = op_valid_q;
  assign bus.op_data      = {kernel, window};
  assign bus.op_index     = op_index_q;
  assign bus.kernel_valid = kernel_valid_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench with handshake scoreboards for STRIDE=1 and STRIDE=3 feeders.
module tb_conv_window_feeder;
  import conv_pkg::*;

  logic       clk = 1'b0;
  logic       rst1 = 1'b0;
  logic       rst3 = 1'b0;
  logic [5:0] kernel_in = '0;
  logic       kernel_load = 1'b0;
  logic       sample_bit = 1'b0;
  logic       sample_valid = 1'b0;
  logic       op_ready = 1'b0;
  bit         sel3 = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [19:0] q1[$];
  logic [19:0] q3[$];

  always #5 clk = ~clk;

  conv_window_feeder_if #(.WIDTH(6), .IDX_W(8)) if1 ();
  conv_window_feeder_if #(.WIDTH(6), .IDX_W(8)) if3 ();

  assign if1.kernel_in    = kernel_in;
  assign if1.kernel_load  = kernel_load;
  assign if1.sample_bit   = sample_bit;
  assign if1.sample_valid = sample_valid;
  assign if1.op_ready     = op_ready;
  assign if3.kernel_in    = kernel_in;
  assign if3.kernel_load  = kernel_load;
  assign if3.sample_bit   = sample_bit;
  assign if3.sample_valid = sample_valid;
  assign if3.op_ready     = op_ready;

  conv_window_feeder #(.WIDTH(6), .STRIDE(1), .IDX_W(8)) u_s1 (
    .clock (clk),
    .reset (rst1),
    .bus   (if1.slave)
  );

  conv_window_feeder #(.WIDTH(6), .STRIDE(3), .IDX_W(8)) u_s3 (
    .clock (clk),
    .reset (rst3),
    .bus   (if3.slave)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Scoreboards: a counted handshake pops one expected {index, data} entry.
  always @(negedge clk) begin
    if (rst1 && if1.op_valid && op_ready && !kernel_load) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL s1_unexpected_op got %h expected none", {if1.op_index, if1.op_data});
      end else begin
        check("s1_op", 32'({if1.op_index, if1.op_data}), 32'(q1.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rst3 && if3.op_valid && op_ready && !kernel_load) begin
      if (q3.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL s3_unexpected_op got %h expected none", {if3.op_index, if3.op_data});
      end else begin
        check("s3_op", 32'({if3.op_index, if3.op_data}), 32'(q3.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [5:0] k);
    kernel_in   = k;
    kernel_load = 1'b1;
    tick();
    kernel_load = 1'b0;
  endtask

  task automatic send(input logic b);
    int n = 0;
    sample_valid = 1'b1;
    sample_bit   = b;
    while (!(sel3 ? if3.sample_ready : if1.sample_ready)) begin
      if (n == 40) begin
        checks++;
        errors++;
        $display("FAIL send_timeout got sample_ready=0 expected 1");
        break;
      end
      tick();
      n++;
    end
    tick();
    sample_valid = 1'b0;
  endtask

  // Sends bits[0] first, so bits[] reads as the resulting window.
  task automatic sendv(input logic [5:0] bits, input int n);
    for (int i = 0; i < n; i++) send(bits[i]);
  endtask

  initial begin
    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      kernel_in    = 6'($urandom);
      kernel_load  = 1'($urandom);
      sample_bit   = 1'($urandom);
      sample_valid = 1'($urandom);
      op_ready     = 1'($urandom);
      tick();
    end
    check("rst_op_valid",     32'(if1.op_valid),     32'd0);
    check("rst_op_data",      32'(if1.op_data),      32'd0);
    check("rst_op_index",     32'(if1.op_index),     32'd0);
    check("rst_sample_ready", 32'(if1.sample_ready), 32'd0);
    check("rst_kernel_valid", 32'(if1.kernel_valid), 32'd0);
    kernel_load  = 1'b0;
    sample_valid = 1'b1;
    op_ready     = 1'b0;
    rst1         = 1'b1;
    tick();
    check("nokernel_ready",        32'(if1.sample_ready), 32'd0);
    check("nokernel_kernel_valid", 32'(if1.kernel_valid), 32'd0);
    sample_valid = 1'b0;

    // Basic window
    op_ready = 1'b1;
    load(6'b101101);
    check("load_kernel_valid", 32'(if1.kernel_valid), 32'd1);
    check("load_sample_ready", 32'(if1.sample_ready), 32'd1);
    q1.push_back({8'd0, 12'hB6B});
    sendv(6'b101011, 5);
    check("early_op_valid", 32'(if1.op_valid), 32'd0);
    send(1'b1);
    check("latency_op_valid", 32'(if1.op_valid), 32'd1);
    check("latency_op_data",  32'(if1.op_data),  32'hB6B);
    tick();
    check("one_cycle_op_valid", 32'(if1.op_valid), 32'd0);
    check("basic_op_index",     32'(if1.op_index), 32'd1);

    // Stride-1 slide
    q1.push_back({8'd1, 12'hB55});
    send(1'b0);
    tick();
    check("slide_op_index", 32'(if1.op_index), 32'd2);

    // Backpressure
    op_ready = 1'b0;
    load(6'b101101);
    q1.push_back({8'd2, 12'hB6B});
    sendv(6'b101011, 6);
    sample_valid = 1'b1;
    sample_bit   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_op_valid",     32'(if1.op_valid),     32'd1);
      check("bp_op_data",      32'(if1.op_data),      32'hB6B);
      check("bp_sample_ready", 32'(if1.sample_ready), 32'd0);
      tick();
    end
    q1.push_back({8'd3, 12'hB75});
    op_ready = 1'b1;
    tick();
    check("bp_hs_op_index",     32'(if1.op_index),     32'd3);
    check("bp_hs_sample_ready", 32'(if1.sample_ready), 32'd1);
    tick();
    sample_valid = 1'b0;
    check("bp_next_op_valid", 32'(if1.op_valid), 32'd1);
    tick();
    check("bp_next_op_index", 32'(if1.op_index), 32'd4);

    // Kernel load during HOLD with op_ready high
    op_ready = 1'b0;
    load(6'b101101);
    sendv(6'b101011, 6);
    check("hold_op_data", 32'(if1.op_data), 32'hB6B);
    kernel_in   = 6'b111111;
    kernel_load = 1'b1;
    op_ready    = 1'b1;
    tick();
    kernel_load = 1'b0;
    check("reload_op_valid",     32'(if1.op_valid),     32'd0);
    check("reload_op_index",     32'(if1.op_index),     32'd4);
    check("reload_sample_ready", 32'(if1.sample_ready), 32'd1);
    q1.push_back({8'd4, 12'hFFF});
    sendv(6'b111111, 5);
    check("reload_need6", 32'(if1.op_valid), 32'd0);
    send(1'b1);
    tick();
    check("reload_op_index_after", 32'(if1.op_index), 32'd5);

    // Mid-operation reset
    load(6'b000111);
    sendv(6'b000101, 3);
    rst1 = 1'b0;
    tick();
    rst1 = 1'b1;
    check("mid_rst_sample_ready", 32'(if1.sample_ready), 32'd0);
    check("mid_rst_op_index",     32'(if1.op_index),     32'd0);
    check("mid_rst_kernel_valid", 32'(if1.kernel_valid), 32'd0);
    check("mid_rst_op_data",      32'(if1.op_data),      32'd0);
    sample_valid = 1'b1;
    sample_bit   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("mid_rst_ignored", 32'(if1.sample_ready), 32'd0);
      tick();
    end
    sample_valid = 1'b0;
    load(6'b110011);
    // Kernel load and a sample in the same cycle: the sample is dropped.
    kernel_in    = 6'b110011;
    kernel_load  = 1'b1;
    sample_valid = 1'b1;
    sample_bit   = 1'b1;
    tick();
    kernel_load  = 1'b0;
    sample_valid = 1'b0;
    q1.push_back({8'd0, 12'hCE6});
    sendv(6'b100110, 5);
    check("collide_need6", 32'(if1.op_valid), 32'd0);
    send(1'b1);
    tick();
    check("collide_op_index", 32'(if1.op_index), 32'd1);

    // STRIDE=3 instance
    rst1 = 1'b0;
    rst3 = 1'b1;
    sel3 = 1'b1;
    op_ready = 1'b1;
    load(6'b101101);
    q3.push_back({8'd0, 12'hB6B});
    sendv(6'b101011, 6);
    tick();
    q3.push_back({8'd1, 12'hB65});
    send(1'b0);
    send(1'b0);
    check("s3_wait_op_valid", 32'(if3.op_valid), 32'd0);
    send(1'b1);
    check("s3_op_valid", 32'(if3.op_valid), 32'd1);
    check("s3_op_data",  32'(if3.op_data),  32'hB65);
    tick();
    check("s3_op_index", 32'(if3.op_index), 32'd2);

    tick();
    check("s1_queue_drained", 32'(q1.size()), 32'd0);
    check("s3_queue_drained", 32'(q3.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_window_feeder.md
Name: conv_window_feeder

Overview:
- Upstream operand stage for the 6-bit binary convolver (AND-popcount core).
- Holds a 6-bit kernel and builds a sliding window over a serial sample-bit stream.
- Presents each complete {kernel, window} pair as a 12-bit operand word through a valid/ready handshake. The downstream core latches it on its load cycle.
- Supports a configurable stride and backpressure while the core is busy.

Parameters:
- WIDTH, 6: kernel/window length in bits.
- STRIDE, 1: new samples required between successive windows; legal range 1..WIDTH.
- IDX_W, 8: width of the emitted-window index counter.

Ports:
- clock  in  1  single system clock; all state updates on posedge.
- reset  in  1  synchronous, active-low: state clears on a posedge when reset==0.
- kernel_in  in  WIDTH  kernel bits; bit 0 pairs with the oldest window sample.
- kernel_load  in  1  capture kernel_in and flush the window.
- sample_bit  in  1  serial sample data.
- sample_valid  in  1  sample_bit is valid this cycle.
- sample_ready  out  1  feeder accepts a sample this cycle.
- op_valid  out  1  op_data holds a complete operand pair.
- op_ready  in  1  downstream accepts op_data.
- op_data  out  2*WIDTH  {kernel[WIDTH-1:0], window[WIDTH-1:0]}; kernel in the upper half, window in the lower half.
- op_index  out  IDX_W  count of completed handshakes.
- kernel_valid  out  1  a kernel has been loaded since reset.

Behaviour:
- Reset (reset==0 at posedge):
  - state=NOKERNEL; window=0, kernel=0, need_cnt=WIDTH.
  - op_valid=0, op_data=0, op_index=0, kernel_valid=0, sample_ready=0.
  - Takes effect in any state; a pending operand is dropped.
- States: NOKERNEL, COLLECT, HOLD.
- sample_ready = (state==COLLECT). It is a registered-state decode only, with no combinational path from inputs.
- A sample is accepted when sample_valid && sample_ready:
  - window <= {sample_bit, window[WIDTH-1:1]}, so the newest sample is at the MSB and the oldest at bit 0.
  - need_cnt decrements.
- NOKERNEL -> COLLECT on kernel_load. Kernel is captured, window cleared, need_cnt=WIDTH, kernel_valid<=1.
- COLLECT -> HOLD when a sample is accepted with need_cnt==1.
  - op_valid rises the next cycle (1-cycle latency from the final sample accept).
  - op_data reflects the updated window.
- HOLD:
  - op_valid=1; op_data and op_index are stable until handshake.
  - sample_ready=0; sample_valid is ignored and no sample is lost, because the upstream holds it.
- Handshake (op_valid && op_ready): next cycle op_valid=0, op_index+=1, state=COLLECT, need_cnt=STRIDE. The window is retained for overlap.
- op_index wraps from 2^IDX_W-1 to 0.
- kernel_load in COLLECT or HOLD:
  - Kernel is re-captured, window=0, need_cnt=WIDTH, state=COLLECT.
  - op_valid drops next cycle, even if op_ready is high that same cycle. That handshake does not count and op_index is unchanged.
- kernel_load and an accepted sample in the same cycle: kernel_load wins and the sample is discarded.
- STRIDE==WIDTH gives non-overlapping windows. STRIDE==1 gives a fully sliding window.
- Steady-state throughput: one window per STRIDE accepted samples plus one HOLD cycle minimum.
- No arithmetic beyond the counters. need_cnt is $clog2(WIDTH+1) bits and never underflows.

Decomposition:
- Shared package conv_pkg:
  - state enum (NOKERNEL, COLLECT, HOLD).
  - constant CONV_WIDTH=6.
  - op_data field offsets (KERNEL_LSB=6, WINDOW_LSB=0).
- One natural sub-module: window_shift_reg. It is a WIDTH-bit shift-in-at-MSB register with clear and shift-enable, reused for the window.
- FSM, counters and the handshake stay in conv_window_feeder.

Test Plan:
1. Reset: hold reset=0 for 2 cycles, random inputs -> op_valid=0, op_data=0, op_index=0, sample_ready=0, kernel_valid=0.
2. Basic window: kernel_load with kernel_in=6'b101101, then samples 1,1,0,1,0,1 back-to-back, op_ready=1 -> op_valid high exactly 1 cycle after the 6th accept, op_data=12'hB6B, op_index 0->1.
3. Backpressure: same as test 2 with op_ready=0 for 5 cycles and sample_valid=1 throughout -> op_valid and op_data=12'hB6B stable, sample_ready=0, no sample consumed. Handshake occurs on cycle 6.
4. Stride 1 slide: after test 2, one sample 0 -> op_data=12'b101101_010101, op_index=2. With STRIDE=3, three samples are needed before op_valid.
5. kernel_load during HOLD with op_ready=1 the same cycle: kernel_in=6'b111111 -> op_valid drops, op_index unchanged. Six new samples are required; all-ones samples give op_data=12'hFFF.
6. Mid-operation reset: reset=0 for 1 cycle after 3 accepted samples -> NOKERNEL, sample_ready=0. Samples are ignored until a new kernel_load, after which 6 samples are required.
